door_lock_ctrl: RTL and testbench



---
 rtl/door_lock_ctrl_pkg.sv | 42 ++++
 rtl/door_lock_ctrl_ms_tick_gen.sv | 26 ++
 rtl/door_lock_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_door_lock_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/door_lock_ctrl_pkg.sv
// Shared types and constants for the door lock sequencer: FSM states, key codes,
// display digit packing and small timer/BCD helpers.
package door_lock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_UNLOCKED,
        ST_DOOR_OPEN,
        ST_LOCKOUT
    } state_e;

    localparam logic [3:0]  KEY_CONFIRM = 4'hE;
    localparam logic [3:0]  KEY_CLEAR   = 4'hF;
    localparam logic [3:0]  BLANK_DIGIT = 4'hF;
    localparam logic [23:0] BLANK_DISP  = {6{BLANK_DIGIT}};

    // Layout matches bcdPac: HEX5 in the MSBs, HEX0 in the LSBs.
    typedef struct packed {
        logic [3:0] hex5;
        logic [3:0] hex4;
        logic [3:0] hex3;
        logic [3:0] hex2;
        logic [3:0] hex1;
        logic [3:0] hex0;
    } bcd_pac_t;

    function automatic logic [31:0] tmr_step(input logic [31:0] t, input logic tick,
                                             input logic [31:0] lim);
        return (tick && t < lim) ? t + 32'd1 : t;
    endfunction

    // Remaining milliseconds -> whole seconds rounded up, two BCD digits, capped at 99.
    function automatic logic [7:0] secs_bcd(input logic [31:0] ms);
        logic [31:0] s;
        s = (ms + 32'd999) / 32'd1000;
        if (s > 32'd99) s = 32'd99;
        return {4'(s / 32'd10), 4'(s % 32'd10)};
    endfunction

endpackage

// File: rtl/door_lock_ctrl_ms_tick_gen.sv
// Free-running divider producing a one-cycle pulse every millisecond of CLK_HZ.
module ms_tick_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV  = (CLK_HZ >= 2000) ? CLK_HZ / 1000 : 1;
    localparam logic [31:0] LAST = 32'(DIV - 1);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/door_lock_ctrl.sv
// Door lock main sequencer: PIN entry/check, unlock/autolock, door alarm, lockout.
// Optional key-press beep enabled by defining DOOR_LOCK_KEYBEEP_EN.
module door_lock_ctrl
    import door_lock_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned PIN_DIGITS    = 4,
    parameter int unsigned MAX_TRIES     = 3,
    parameter int unsigned ENTRY_TO_MS   = 5000,
    parameter int unsigned AUTOLOCK_MS   = 5000,
    parameter int unsigned DOOR_ALARM_MS = 10000,
    parameter int unsigned LOCKOUT_MS    = 30000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              key_code,
    input  logic                    key_valid,
    input  logic                    sensor_de_contato,
    input  logic                    botao_interno,
    input  logic                    setup_on,
    input  logic [4*PIN_DIGITS-1:0] pin_ref,
    output logic                    tranca,
    output logic                    bip,
    output logic [23:0]             disp_digits,
    output logic                    disp_en
);

    localparam int unsigned CW = $clog2(PIN_DIGITS + 1);
    localparam int unsigned TW = $clog2(MAX_TRIES + 1);
    localparam logic [CW-1:0] PD_C = CW'(PIN_DIGITS);
    localparam logic [TW-1:0] MT_C = TW'(MAX_TRIES);

    logic tick;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    state_e                  state_q, state_d;
    logic [4*PIN_DIGITS-1:0] entry_q, entry_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           try_q, try_d, try_inc;
    logic [31:0]             timer_q, timer_d;
    logic                    btn_q, btn_edge, is_digit, alarm;
    logic                    tranca_q, tranca_d, bip_q, bip_d, disp_en_q, disp_en_d;
    bcd_pac_t                disp_q, disp_d;
    logic [23:0]             flat;
`ifdef DOOR_LOCK_KEYBEEP_EN
    localparam logic [6:0] BEEP_MS = 7'd100;
    logic [6:0] beep_q, beep_d;
`endif

    assign btn_edge = botao_interno && !btn_q;
    assign is_digit = key_code <= 4'd9;
    assign try_inc  = try_q + 1'b1;

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        try_d   = try_q;
        timer_d = timer_q;
        flat    = BLANK_DISP;
        disp_d  = BLANK_DISP;

        case (state_q)
            ST_IDLE: begin
                if (btn_edge) begin
                    state_d = ST_UNLOCKED;
                end else if (key_valid && is_digit) begin
                    state_d      = ST_ENTRY;
                    entry_d      = '0;
                    entry_d[3:0] = key_code;
                    cnt_d        = CW'(1);
                end
            end
            ST_ENTRY: begin
                timer_d = tmr_step(timer_q, tick, ENTRY_TO_MS);
                if (btn_edge) begin
                    state_d = ST_UNLOCKED;
                end else if (key_valid) begin
                    timer_d = '0;
                    if (is_digit && cnt_q < PD_C) begin
                        entry_d      = entry_q << 4;
                        entry_d[3:0] = key_code;
                        cnt_d        = cnt_q + 1'b1;
                    end else if (key_code == KEY_CLEAR) begin
                        state_d = ST_IDLE;
                    end else if (key_code == KEY_CONFIRM) begin
                        state_d = ST_CHECK;
                    end
                end else if (timer_d >= ENTRY_TO_MS) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (cnt_q == PD_C && entry_q == pin_ref) begin
                    state_d = ST_UNLOCKED;
                    try_d   = '0;
                end else begin
                    try_d   = try_inc;
                    state_d = (try_inc == MT_C) ? ST_LOCKOUT : ST_IDLE;
                end
            end
            ST_UNLOCKED: begin
                timer_d = tmr_step(timer_q, tick, AUTOLOCK_MS);
                if (!sensor_de_contato)        state_d = ST_DOOR_OPEN;
                else if (timer_d >= AUTOLOCK_MS) state_d = ST_IDLE;
            end
            ST_DOOR_OPEN: begin
                timer_d = tmr_step(timer_q, tick, DOOR_ALARM_MS);
                if (sensor_de_contato) state_d = ST_IDLE;
            end
            ST_LOCKOUT: begin
                timer_d = tmr_step(timer_q, tick, LOCKOUT_MS);
                if (timer_d >= LOCKOUT_MS) begin
                    state_d = ST_IDLE;
                    try_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Setup freezes everything except a running lockout, which must still expire.
        if (setup_on && state_q != ST_LOCKOUT) begin
            state_d = ST_IDLE;
            try_d   = try_q;
        end
        if (state_d != state_q) timer_d = '0;
        if (state_d != ST_ENTRY && state_d != ST_CHECK) begin
            entry_d = '0;
            cnt_d   = '0;
        end

        alarm    = (state_d == ST_DOOR_OPEN) && (timer_d >= DOOR_ALARM_MS);
        tranca_d = !(state_d == ST_UNLOCKED || state_d == ST_DOOR_OPEN);
`ifdef DOOR_LOCK_KEYBEEP_EN
        beep_d = beep_q;
        if (tick && beep_q != '0) beep_d = beep_q - 1'b1;
        if (key_valid && !setup_on && state_q != ST_LOCKOUT) beep_d = BEEP_MS;
        bip_d = (alarm || beep_d != '0) && !setup_on;
`else
        bip_d = alarm && !setup_on;
`endif
        disp_en_d = !setup_on;

        if (state_d == ST_ENTRY) begin
            for (int unsigned i = 0; i < PIN_DIGITS; i++)
                if (i < 32'(cnt_d)) flat[4*i +: 4] = entry_d[4*i +: 4];
            disp_d = flat;
        end else if (state_d == ST_LOCKOUT) begin
            {disp_d.hex1, disp_d.hex0} = secs_bcd(LOCKOUT_MS - timer_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            entry_q   <= '0;
            cnt_q     <= '0;
            try_q     <= '0;
            timer_q   <= '0;
            btn_q     <= 1'b0;
            tranca_q  <= 1'b1;
            bip_q     <= 1'b0;
            disp_q    <= BLANK_DISP;
            disp_en_q <= 1'b1;
`ifdef DOOR_LOCK_KEYBEEP_EN
            beep_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            cnt_q     <= cnt_d;
            try_q     <= try_d;
            timer_q   <= timer_d;
            btn_q     <= botao_interno;
            tranca_q  <= tranca_d;
            bip_q     <= bip_d;
            disp_q    <= disp_d;
            disp_en_q <= disp_en_d;
`ifdef DOOR_LOCK_KEYBEEP_EN
            beep_q    <= beep_d;
`endif
        end
    end

    assign tranca      = tranca_q;
    assign bip         = bip_q;
    assign disp_digits = disp_q;
    assign disp_en     = disp_en_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed bench for door_lock_ctrl with a 1 ms tick every clock (CLK_HZ=1000).
module tb_door_lock_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        sensor_de_contato;
    logic        botao_interno;
    logic        setup_on;
    logic [15:0] pin_ref;
    logic        tranca;
    logic        bip;
    logic [23:0] disp_digits;
    logic        disp_en;

    int n_vec = 0;
    int n_err = 0;

    door_lock_ctrl #(
        .CLK_HZ        (1000),
        .PIN_DIGITS    (4),
        .MAX_TRIES     (3),
        .ENTRY_TO_MS   (5000),
        .AUTOLOCK_MS   (5000),
        .DOOR_ALARM_MS (10000),
        .LOCKOUT_MS    (30000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .key_code          (key_code),
        .key_valid         (key_valid),
        .sensor_de_contato (sensor_de_contato),
        .botao_interno     (botao_interno),
        .setup_on          (setup_on),
        .pin_ref           (pin_ref),
        .tranca            (tranca),
        .bip               (bip),
        .disp_digits       (disp_digits),
        .disp_en           (disp_en)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        step(1);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    initial begin
        rst = 1'b1; key_code = 4'h0; key_valid = 1'b0; sensor_de_contato = 1'b1;
        botao_interno = 1'b0; setup_on = 1'b0; pin_ref = 16'h1234;
        step(2);
        check_eq("rst_tranca", 32'(tranca), 32'd1);
        check_eq("rst_bip", 32'(bip), 32'd0);
        check_eq("rst_disp", 32'(disp_digits), 32'hFFFFFF);
        check_eq("rst_disp_en", 32'(disp_en), 32'd1);
        rst = 1'b0;
        step(1);

        // Correct PIN, then autolock with the door kept closed
        press(4'd1); check_eq("entry_1", 32'(disp_digits), 32'hFFFFF1);
        press(4'd2); check_eq("entry_12", 32'(disp_digits), 32'hFFFF12);
        press(4'd3);
        press(4'd4); check_eq("entry_1234", 32'(disp_digits), 32'hFF1234);
        press(4'hE); check_eq("check_locked", 32'(tranca), 32'd1);
        step(1);
        check_eq("unlock_tranca", 32'(tranca), 32'd0);
        check_eq("unlock_disp", 32'(disp_digits), 32'hFFFFFF);
        step(4999); check_eq("autolock_pre", 32'(tranca), 32'd0);
        step(1);    check_eq("autolock", 32'(tranca), 32'd1);

        // Three wrong PINs -> lockout countdown
        for (int a = 0; a < 3; a++) begin
            press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(4'hE);
            step(1);
            if (a < 2) check_eq("wrong_idle", 32'(disp_digits), 32'hFFFFFF);
        end
        check_eq("lock_disp30", 32'(disp_digits), 32'hFFFF30);
        check_eq("lock_tranca", 32'(tranca), 32'd1);
        press(4'd5); check_eq("lock_key_ign", 32'(disp_digits), 32'hFFFF30);
        botao_interno = 1'b1; step(1);
        check_eq("lock_btn_ign", 32'(tranca), 32'd1);
        botao_interno = 1'b0;
        step(997);   check_eq("lock_k999", 32'(disp_digits), 32'hFFFF30);
        step(1);     check_eq("lock_k1000", 32'(disp_digits), 32'hFFFF29);
        step(28999); check_eq("lock_k29999", 32'(disp_digits), 32'hFFFF01);
        step(1);     check_eq("lock_exit", 32'(disp_digits), 32'hFFFFFF);
        press(4'd1); check_eq("post_lock_key", 32'(disp_digits), 32'hFFFFF1);
        press(4'hF); check_eq("clear", 32'(disp_digits), 32'hFFFFFF);

        // Extra digit ignored, unlock, door left open -> alarm
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        check_eq("extra_digit", 32'(disp_digits), 32'hFF1234);
        press(4'hE); step(1);
        check_eq("unlock2", 32'(tranca), 32'd0);
        sensor_de_contato = 1'b0; step(1);
        check_eq("open_tranca", 32'(tranca), 32'd0);
        step(9999); check_eq("alarm_pre", 32'(bip), 32'd0);
        step(1);    check_eq("alarm", 32'(bip), 32'd1);
        sensor_de_contato = 1'b1; step(1);
        check_eq("close_bip", 32'(bip), 32'd0);
        check_eq("close_tranca", 32'(tranca), 32'd1);

        // Forced door in IDLE, entry timeout, clear
        sensor_de_contato = 1'b0; step(1);
        check_eq("forced_door", 32'(tranca), 32'd1);
        sensor_de_contato = 1'b1;
        press(4'd7); press(4'd8);
        check_eq("entry_78", 32'(disp_digits), 32'hFFFF78);
        step(4999); check_eq("timeout_pre", 32'(disp_digits), 32'hFFFF78);
        step(1);    check_eq("timeout", 32'(disp_digits), 32'hFFFFFF);
        press(4'd1); press(4'd2);
        check_eq("entry_12b", 32'(disp_digits), 32'hFFFF12);
        press(4'hF); check_eq("clear2", 32'(disp_digits), 32'hFFFFFF);

        // Internal button, and button beating a simultaneous key
        botao_interno = 1'b1; step(1);
        check_eq("btn_unlock", 32'(tranca), 32'd0);
        botao_interno = 1'b0; step(5000);
        check_eq("btn_relock", 32'(tranca), 32'd1);
        key_code = 4'd5; key_valid = 1'b1; botao_interno = 1'b1; step(1);
        key_valid = 1'b0; botao_interno = 1'b0;
        check_eq("btn_wins_tranca", 32'(tranca), 32'd0);
        check_eq("btn_wins_disp", 32'(disp_digits), 32'hFFFFFF);
        step(5000);
        check_eq("btn_wins_relock", 32'(tranca), 32'd1);
        check_eq("digit_dropped", 32'(disp_digits), 32'hFFFFFF);

        // Setup mid-entry
        press(4'd1); press(4'd2);
        setup_on = 1'b1; step(1);
        check_eq("setup_disp_en", 32'(disp_en), 32'd0);
        check_eq("setup_tranca", 32'(tranca), 32'd1);
        check_eq("setup_disp", 32'(disp_digits), 32'hFFFFFF);
        setup_on = 1'b0; step(1);
        check_eq("setup_off_en", 32'(disp_en), 32'd1);
        press(4'd3); check_eq("setup_cleared", 32'(disp_digits), 32'hFFFFF3);
        press(4'hF);

        // Reset while the door alarm is sounding
        botao_interno = 1'b1; step(1);
        botao_interno = 1'b0; sensor_de_contato = 1'b0; step(1);
        step(10000); check_eq("alarm2", 32'(bip), 32'd1);
        rst = 1'b1; step(1);
        check_eq("rst_door_tranca", 32'(tranca), 32'd1);
        check_eq("rst_door_bip", 32'(bip), 32'd0);
        rst = 1'b0; sensor_de_contato = 1'b1; step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
